// File: rtl/mem_arbiter.sv
// Shares one single-ported RAM between the instruction-fetch and load/store ports.
// Data accesses win, but a pending fetch is forced after FAIR_LIMIT data grants.
//
//   state  | meaning
//   IDLE   | no RAM transaction; arbitrate between pending requests
//   DSERVE | RAM driven from the data port until ACCESS/ERROR/timeout/drop
//   ISERVE | RAM driven from the fetch port until ACCESS/ERROR/timeout/drop
module mem_arbiter #(
  parameter int FAIR_LIMIT = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DSERVE = 2'd1;
  localparam logic [1:0] ISERVE = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam int FW = ($clog2(FAIR_LIMIT + 1) < 3) ? 3 : $clog2(FAIR_LIMIT + 1);
  localparam int TW = ($clog2(TIMEOUT) < 1) ? 1 : $clog2(TIMEOUT);

  localparam logic [FW-1:0] FAIR_MAX = FW'(FAIR_LIMIT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [31:0]   BAD_DATA = 32'hBAD1_BAD1;

  logic [1:0]    state_q, state_d;
  logic [FW-1:0] fair_cnt_q, fair_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          memerr_q, memerr_d;

  logic d_req;
  logic fail_now;
  logic err_now;

  assign d_req    = dREN | dWEN;
  assign fail_now = (ramstate == RAM_ERROR) || (tmo_cnt_q == TMO_LAST);
  // The flag is visible in the same cycle the failing transaction is released.
  assign memerr   = memerr_q | err_now;

  always_comb begin
    state_d    = state_q;
    fair_cnt_d = fair_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    memerr_d   = memerr_q;
    err_now    = 1'b0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = 32'h0;
    ramstore   = 32'h0;
    iload      = 32'h0;
    dload      = 32'h0;
    iwait      = iREN;
    dwait      = d_req;

    case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        if (!iREN) fair_cnt_d = '0;
        if (d_req && !(iREN && (fair_cnt_q == FAIR_MAX))) state_d = DSERVE;
        else if (iREN)                                     state_d = ISERVE;
      end

      DSERVE: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (ramstate == RAM_ACCESS) begin
            dwait   = 1'b0;
            dload   = ramload;
            state_d = IDLE;
            if (iREN && (fair_cnt_q < FAIR_MAX)) fair_cnt_d = fair_cnt_q + FW'(1);
          end else if (fail_now) begin
            dwait    = 1'b0;
            dload    = BAD_DATA;
            err_now  = 1'b1;
            memerr_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      ISERVE: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == RAM_ACCESS) begin
            iwait      = 1'b0;
            iload      = ramload;
            fair_cnt_d = '0;
            state_d    = IDLE;
          end else if (fail_now) begin
            iwait    = 1'b0;
            iload    = BAD_DATA;
            err_now  = 1'b1;
            memerr_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      fair_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      memerr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fair_cnt_q <= fair_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      memerr_q   <= memerr_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each expected completion (port, load data) is queued
// when its request is issued and retired by a monitor when the port's wait drops.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload, ramload_v;
  logic [1:0]  ramstate;
  logic        memerr;
  bit          model_en = 1'b0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  localparam logic [31:0] BAD = 32'hBAD1_BAD1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_i;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  always #5 CLK = ~CLK;

  // Small RAM model: read data derived from the address, or a fixed value.
  assign ramload = model_en ? (ramaddr ^ 32'hA5A5_0000) : ramload_v;

  mem_arbiter #(.FAIR_LIMIT(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input bit is_i, input logic [31:0] data);
    exp_t e;
    e.is_i = is_i;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input bit is_i, input logic [31:0] data);
    exp_t e;
    chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_port_is_i", 32'(is_i), 32'(e.is_i));
      chk(is_i ? "sb_iload" : "sb_dload", data, e.data);
    end
  endtask

  always @(negedge CLK) begin
    if (iREN && !iwait)           sb_pop(1'b1, iload);
    if ((dREN || dWEN) && !dwait) sb_pop(1'b0, dload);
  end

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
    ramstate = FREE; ramload_v = 32'h0;
    #12;
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_iload", iload, 32'h0);
    chk("rst_memerr", 32'(memerr), 32'd0);
    chk("rst_iwait_follows_req", 32'(iwait), 32'd1);
    iREN = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;

    // single fetch, 1-cycle RAM
    next_cyc();
    iREN = 1'b1; iaddr = 32'h40; ramload_v = 32'h8C22_0004; ramstate = FREE;
    sb_push(1'b1, 32'h8C22_0004);
    @(negedge CLK);
    chk("t1_idle_ramREN", 32'(ramREN), 32'd0);
    chk("t1_idle_iwait", 32'(iwait), 32'd1);
    next_cyc();
    ramstate = ACCESS;
    @(negedge CLK);
    chk("t1_ramREN", 32'(ramREN), 32'd1);
    chk("t1_ramaddr", ramaddr, 32'h40);
    chk("t1_iwait", 32'(iwait), 32'd0);
    chk("t1_iload", iload, 32'h8C22_0004);
    next_cyc();
    iREN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    chk("t1_c2_ramREN", 32'(ramREN), 32'd0);
    chk("t1_c2_ramaddr", ramaddr, 32'h0);

    // write with 3 BUSY cycles then ACCESS
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramstate = BUSY;
    ramload_v = 32'h0000_1234;
    sb_push(1'b0, 32'h0000_1234);
    for (int c = 1; c <= 4; c++) begin
      next_cyc();
      if (c == 4) ramstate = ACCESS;
      @(negedge CLK);
      chk($sformatf("t2_ramWEN_c%0d", c), 32'(ramWEN), 32'd1);
      chk($sformatf("t2_ramREN_c%0d", c), 32'(ramREN), 32'd0);
      chk($sformatf("t2_ramaddr_c%0d", c), ramaddr, 32'h100);
      chk($sformatf("t2_ramstore_c%0d", c), ramstore, 32'hDEAD_BEEF);
      chk($sformatf("t2_dwait_c%0d", c), 32'(dwait), (c < 4) ? 32'd1 : 32'd0);
    end
    next_cyc();
    dWEN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    chk("t2_after_ramWEN", 32'(ramWEN), 32'd0);

    // contention: expected grant order D,D,D,D,I,D,D,D,D,I
    model_en = 1'b1; ramstate = ACCESS;
    iaddr = 32'h80; daddr = 32'h200; iREN = 1'b1; dREN = 1'b1;
    for (int g = 0; g < 10; g++) begin
      if (g == 4 || g == 9) sb_push(1'b1, 32'h80 ^ 32'hA5A5_0000);
      else                  sb_push(1'b0, 32'h200 ^ 32'hA5A5_0000);
    end
    repeat (19) @(posedge CLK);
    @(negedge CLK);
    next_cyc();
    iREN = 1'b0; dREN = 1'b0; model_en = 1'b0; ramstate = FREE;
    chk("t3_grants_left", 32'(sb_q.size()), 32'd0);

    // timeout with RAM stuck BUSY
    dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
    sb_push(1'b0, BAD);
    for (int c = 1; c <= 64; c++) begin
      next_cyc();
      @(negedge CLK);
      if (c == 1) chk("t4_ramREN", 32'(ramREN), 32'd1);
      if (c == 63) begin
        chk("t4_dwait_c63", 32'(dwait), 32'd1);
        chk("t4_memerr_c63", 32'(memerr), 32'd0);
      end
      if (c == 64) begin
        chk("t4_dwait_c64", 32'(dwait), 32'd0);
        chk("t4_dload_c64", dload, BAD);
        chk("t4_memerr_c64", 32'(memerr), 32'd1);
      end
    end
    next_cyc();
    dREN = 1'b0;
    @(negedge CLK);
    chk("t4_memerr_sticky", 32'(memerr), 32'd1);
    chk("t4_idle_ramREN", 32'(ramREN), 32'd0);

    // ERROR during fetch
    iREN = 1'b1; iaddr = 32'h44; ramstate = BUSY;
    sb_push(1'b1, BAD);
    next_cyc();
    ramstate = ERROR;
    @(negedge CLK);
    chk("t5_iwait", 32'(iwait), 32'd0);
    chk("t5_iload", iload, BAD);
    chk("t5_memerr", 32'(memerr), 32'd1);
    next_cyc();
    iREN = 1'b0; ramstate = BUSY;

    // data read dropped mid-BUSY
    dREN = 1'b1; daddr = 32'h500;
    next_cyc();
    @(negedge CLK);
    chk("t5_abort_ramREN_c1", 32'(ramREN), 32'd1);
    chk("t5_abort_dwait_c1", 32'(dwait), 32'd1);
    next_cyc();
    dREN = 1'b0;
    #1;
    chk("t5_abort_ramREN_drop", 32'(ramREN), 32'd0);
    chk("t5_abort_ramaddr_drop", ramaddr, 32'h0);
    next_cyc();
    dREN = 1'b1;
    #1;
    chk("t5_abort_idle_ramREN", 32'(ramREN), 32'd0);
    chk("t5_abort_idle_dwait", 32'(dwait), 32'd1);
    ramload_v = 32'h0000_0077;
    sb_push(1'b0, 32'h0000_0077);
    next_cyc();
    ramstate = ACCESS;
    @(negedge CLK);
    next_cyc();
    dREN = 1'b0; ramstate = BUSY;

    // async reset in the middle of a write
    dWEN = 1'b1; daddr = 32'h600; dstore = 32'hCAFE_F00D;
    next_cyc();
    @(negedge CLK);
    chk("t6_ramWEN_before", 32'(ramWEN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("t6_ramWEN_rst", 32'(ramWEN), 32'd0);
    chk("t6_memerr_rst", 32'(memerr), 32'd0);
    chk("t6_ramaddr_rst", ramaddr, 32'h0);
    chk("t6_dwait_rst", 32'(dwait), 32'd1);
    @(posedge CLK); #1 nRST = 1'b1;
    #1;
    chk("t6_idle_ramWEN", 32'(ramWEN), 32'd0);
    chk("t6_idle_dwait", 32'(dwait), 32'd1);
    ramload_v = 32'h0000_600D;
    sb_push(1'b0, 32'h0000_600D);
    next_cyc();
    ramstate = ACCESS;
    @(negedge CLK);
    chk("t6_ramWEN_again", 32'(ramWEN), 32'd1);
    next_cyc();
    dWEN = 1'b0; ramstate = FREE;
    @(negedge CLK);
    chk("t6_memerr_after", 32'(memerr), 32'd0);

    chk("sb_left", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
